// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 16-bit combinational ALU: decodes one instruction at a time,
// reads operands from the 16x16 register file, holds them for the ALU, then writes back.
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned NREGS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [15:0] inst,
    output logic [7:0]  alu_opcode,
    output logic [15:0] alu_r1,
    output logic [15:0] alu_r2,
    output logic        alu_cin,
    input  logic [15:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic        done,
    output logic        illegal,
    output logic [4:0]  psr,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t      r_state;
    logic [15:0] r_inst;
    logic [15:0] r_res;
    logic [4:0]  r_flags;
    logic [4:0]  r_psr;
    logic [15:0] r_regs [NREGS];
    logic [7:0]  r_opcode;
    logic [15:0] r_r1;
    logic [15:0] r_r2;
    logic        r_cin;
    logic        r_ready;
    logic        r_done;
    logic        r_illegal;
    logic [1:0]  r_cnt;

    logic        w_imm;
    logic [3:0]  w_code;
    logic [3:0]  w_rdest;
    logic [3:0]  w_rsrc;
    logic [15:0] w_r1;
    logic [15:0] w_r2;
    logic        w_legal;
    logic        w_wr;
    logic        w_psr_upd;

    // Decode works off the latched word, which stays put until the next handshake.
    always_comb begin
        w_imm     = (r_inst[15:12] != 4'h0);
        w_code    = w_imm ? r_inst[15:12] : r_inst[7:4];
        w_rdest   = r_inst[11:8];
        w_rsrc    = r_inst[3:0];
        w_r1      = w_imm ? {{8{r_inst[7]}}, r_inst[7:0]} : r_regs[w_rsrc];
        w_r2      = r_regs[w_rdest];
        w_legal   = 1'b0;
        w_psr_upd = 1'b0;
        case (w_code)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8,
            4'h9, 4'hA, 4'hB, 4'hD, 4'hF: w_legal = 1'b1;
            default:                      w_legal = 1'b0;
        endcase
        case (w_code)
            4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: w_psr_upd = 1'b1;
            default:                            w_psr_upd = 1'b0;
        endcase
        w_wr = w_legal && (w_code != 4'hB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_inst    <= '0;
            r_res     <= '0;
            r_flags   <= '0;
            r_psr     <= '0;
            r_opcode  <= '0;
            r_r1      <= '0;
            r_r2      <= '0;
            r_cin     <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inst_valid) begin
                        r_inst  <= inst;
                        r_ready <= 1'b0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // Undefined codes present opcode 0 so the ALU sees a harmless op.
                    r_opcode <= w_legal ? {4'h0, w_code} : 8'h00;
                    r_r1     <= w_r1;
                    r_r2     <= w_r2;
                    r_cin    <= r_psr[0];
                    r_cnt    <= 2'(ALU_LAT - 1);
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_cnt == 2'd0) begin
                        r_res     <= alu_out;
                        r_flags   <= alu_flags;
                        r_done    <= 1'b1;
                        r_illegal <= !w_legal;
                        r_state   <= S_WB;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_WB: begin
                    if (w_wr) begin
                        r_regs[w_rdest] <= r_res;
                    end
                    if (w_psr_upd) begin
                        r_psr <= r_flags;
                    end
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign inst_ready = r_ready;
    assign alu_opcode = r_opcode;
    assign alu_r1     = r_r1;
    assign alu_r2     = r_r2;
    assign alu_cin    = r_cin;
    assign done       = r_done;
    assign illegal    = r_illegal;
    assign psr        = r_psr;
    assign dbg_data   = r_regs[dbg_addr];

endmodule
